gate_response_checker: RTL
==========================

Name: gate_response_checker

Overview:
Self-checking receiver for the two-input gate bank. It samples the bank's seven outputs together with the a/b operands that produced them, and recomputes the expected value of every gate. It counts passes and failures over a run of NUM_VECTORS samples and latches the first failing vector. It sits on the observation side of the gate bank, opposite the a/b stimulus driver, and gives a pass/fail verdict usable in silicon or simulation.

Parameters:
NUM_VECTORS, 4, number of accepted samples per run (1..2**CNT_W-1)
CNT_W, 8, width of pass/fail/index counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a run from IDLE or DONE
in_valid  input  1  sample present on a/b/obs this cycle
in_ready  output  1  checker accepts a sample this cycle
a  input  1  operand a applied to gate bank
b  input  1  operand b applied to gate bank
obs  input  7  observed outputs; bit0 and, 1 or, 2 not(a), 3 nor, 4 nand, 5 xor, 6 xnor
busy  output  1  run in progress
done  output  1  run complete (level, held in DONE)
all_pass  output  1  valid when done: fail_cnt==0
pass_cnt  output  CNT_W  samples matching on all 7 bits
fail_cnt  output  CNT_W  samples with any mismatching bit
first_fail_idx  output  CNT_W  sample index (0-based) of first failure
first_fail_mask  output  7  obs XOR expected for first failure

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, busy=0, done=0, all_pass=0, all counters/index/mask=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=0; start=1 -> RUN, clearing counters, index, mask, and the internal sample index.
- RUN: busy=1, in_ready=1. Accept = in_valid && in_ready.
  - On accept: expected = {~(a^b), a^b, ~(a&b), ~(a|b), ~a, a|b, a&b}; err = obs ^ expected.
  - err==0 -> pass_cnt+1; otherwise fail_cnt+1.
  - If this is the first failure of the run, latch first_fail_idx=sample index and first_fail_mask=err.
  - Counters update on the edge after accept (1-cycle latency).
  - Accept of sample index NUM_VECTORS-1 -> DONE at the same edge.
- DONE: busy=0, in_ready=0, done=1, all_pass=(fail_cnt==0). Results hold until start.
  - start in DONE -> RUN with fresh clear.
- in_valid outside RUN: ignored, no count change.
- start during RUN: ignored.
- Simultaneous start and in_valid in IDLE/DONE: only start takes effect; the sample is not accepted.
- X/Z on obs bits counts as mismatch; the err bit is set to 1.
- Counters cannot overflow by construction (pass_cnt+fail_cnt == NUM_VECTORS at done). The parameter check enforces NUM_VECTORS < 2**CNT_W.
- Reset mid-run: immediate return to IDLE; all results lost.

Optional Feature:
GATE_CHK_COVER_EN
- Defined: adds output cov_mask[3:0]. Bit {a,b} is set on each accepted sample and cleared on start. all_pass additionally requires cov_mask==4'hF, meaning every input combination was exercised.
- Undefined: no cov_mask port; all_pass = (fail_cnt==0) only.

Decomposition:
- Shared package gate_chk_pkg:
  - state enum {IDLE, RUN, DONE}.
  - obs bit-index constants (AND_B=0 … XNOR_B=6).
  - GATE_W=7.
- One natural sub-module: gate_expect, combinational a,b -> expected[6:0]. It is reused by any future stimulus-side model.

Test Plan:
- Correct bank, 4 vectors ab=00,01,10,11 after start -> done=1, pass_cnt=4, fail_cnt=0, all_pass=1, first_fail_mask=0.
- Vector 2 (a=1,b=0) with obs bit5 forced 0 -> fail_cnt=1, pass_cnt=3, first_fail_idx=2, first_fail_mask=7'b0100000, all_pass=0.
- Failures at idx 1 (mask 0000001) and idx 3 (mask 1000000) -> fail_cnt=2, first_fail_idx=1, first_fail_mask=7'b0000001.
- in_valid pulses in IDLE, then start plus 4 gapped valid samples -> only the 4 RUN samples counted. done rises exactly 1 cycle after the 4th accept.
- rst_n low after 2 samples -> all outputs 0 immediately. A subsequent start with 4 good samples gives pass_cnt=4.
- With GATE_CHK_COVER_EN: 4 samples all ab=11, correct obs -> cov_mask=4'b1000, all_pass=0. With the macro undefined, the same stimulus gives all_pass=1.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate-bank response checker.
// Bit positions follow the gate bank's seven-output observation bus.
package gate_chk_pkg;

  localparam int GATE_W = 7;

  localparam int AND_B  = 0;
  localparam int OR_B   = 1;
  localparam int NOT_B  = 2;
  localparam int NOR_B  = 3;
  localparam int NAND_B = 4;
  localparam int XOR_B  = 5;
  localparam int XNOR_B = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gate_expect.sv
// Reference model of the two-input gate bank: a/b operands to expected outputs.
// Kept separate so a stimulus-side model can reuse the same truth table.
module gate_expect
  import gate_chk_pkg::*;
(
  input  logic              a,
  input  logic              b,
  output logic [GATE_W-1:0] expected
);

  always_comb begin
    expected         = '0;
    expected[AND_B]  = a & b;
    expected[OR_B]   = a | b;
    expected[NOT_B]  = ~a;
    expected[NOR_B]  = ~(a | b);
    expected[NAND_B] = ~(a & b);
    expected[XOR_B]  = a ^ b;
    expected[XNOR_B] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_response_checker.sv
// Gate-bank response checker: tallies pass/fail over NUM_VECTORS samples, latches first failure.
// Optional `GATE_CHK_COVER_EN adds cov_mask and makes all_pass require full a/b coverage.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              a,
  input  logic              b,
  input  logic [GATE_W-1:0] obs,
  output logic              busy,
  output logic              done,
  output logic              all_pass,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [GATE_W-1:0] first_fail_mask
`ifdef GATE_CHK_COVER_EN
  ,
  output logic [3:0]        cov_mask
`endif
);

  // state | meaning
  // IDLE  | waiting for start; samples ignored
  // RUN   | accepting samples, counting pass/fail
  // DONE  | results held until the next start

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  if (NUM_VECTORS < 1 || NUM_VECTORS >= (1 << CNT_W)) begin : g_param_check
    $error("NUM_VECTORS must lie in 1..2**CNT_W-1");
  end

  state_t            state;
  logic [CNT_W-1:0]  sample_idx;
  logic [GATE_W-1:0] expected;
  logic [GATE_W-1:0] err_raw;
  logic [GATE_W-1:0] err;
  logic              accept;
  logic              sample_ok;
  logic              cov_ok;

  gate_expect u_expect (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  // An unknown obs bit must read as a mismatch, so anything other than a clean 0 sets err.
  always_comb begin
    err_raw = obs ^ expected;
    err     = '1;
    for (int i = 0; i < GATE_W; i++) begin
      err[i] = (err_raw[i] === 1'b0) ? 1'b0 : 1'b1;
    end
  end

  assign accept    = in_valid && in_ready;
  assign sample_ok = (err == '0);

`ifdef GATE_CHK_COVER_EN
  logic [3:0] cov_next;
  assign cov_next = cov_mask | (4'b0001 << {a, b});
  assign cov_ok   = (cov_next == 4'hF);
`else
  assign cov_ok   = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      in_ready        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      all_pass        <= 1'b0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      first_fail_idx  <= '0;
      first_fail_mask <= '0;
      sample_idx      <= '0;
`ifdef GATE_CHK_COVER_EN
      cov_mask        <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RUN;
            in_ready        <= 1'b1;
            busy            <= 1'b1;
            done            <= 1'b0;
            all_pass        <= 1'b0;
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            first_fail_idx  <= '0;
            first_fail_mask <= '0;
            sample_idx      <= '0;
`ifdef GATE_CHK_COVER_EN
            cov_mask        <= '0;
`endif
          end
        end
        RUN: begin
          if (accept) begin
            sample_idx <= sample_idx + ONE;
            if (sample_ok) begin
              pass_cnt <= pass_cnt + ONE;
            end else begin
              fail_cnt <= fail_cnt + ONE;
              if (fail_cnt == '0) begin
                first_fail_idx  <= sample_idx;
                first_fail_mask <= err;
              end
            end
`ifdef GATE_CHK_COVER_EN
            cov_mask <= cov_next;
`endif
            // Verdict uses this sample's result since the counters only update at this edge.
            if (sample_idx == LAST_IDX) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              all_pass <= (fail_cnt == '0) && sample_ok && cov_ok;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
